n64_poll_scheduler: RTL and testbench

Sequences the N64 serial interface: issues periodic poll transactions at a software-set rate, supervises each with a watchdog, retries failures, and escalates repeated failures to a controller reset. It sits between the APB register block and the serial interface, replacing the raw polling_enable/controller_reset levels with scheduled one-cycle commands. It also publishes a latched button snapshot, connection status and statistics for readback.

---
 rtl/n64_pkg.sv | 35 +++
 rtl/n64_poll_scheduler_if.sv | 19 +
 rtl/n64_down_counter.sv | 25 ++
 rtl/n64_poll_scheduler.sv | 138 +++++++++++++
 tb/tb_n64_poll_scheduler.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/n64_pkg.sv
// Shared N64 definitions: scheduler state encoding, default timing constants,
// and the button-word bit layout used by the APB register block.
package n64_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT       = 2'd1,
    ST_POLL       = 2'd2,
    ST_RESET_CTRL = 2'd3
  } sched_state_t;

  localparam int TIMEOUT_CYCLES = 20000;
  localparam int MAX_FAILS      = 3;
  localparam int RESET_HOLD     = 16;

  // Button word bit positions, MSB first as the controller shifts them out
  localparam int BTN_A       = 31;
  localparam int BTN_B       = 30;
  localparam int BTN_Z       = 29;
  localparam int BTN_START   = 28;
  localparam int BTN_D_UP    = 27;
  localparam int BTN_D_DOWN  = 26;
  localparam int BTN_D_LEFT  = 25;
  localparam int BTN_D_RIGHT = 24;
  localparam int BTN_L       = 21;
  localparam int BTN_R       = 20;
  localparam int BTN_C_UP    = 19;
  localparam int BTN_C_DOWN  = 18;
  localparam int BTN_C_LEFT  = 17;
  localparam int BTN_C_RIGHT = 16;
  localparam int STICK_X_LSB = 8;
  localparam int STICK_Y_LSB = 0;
  localparam int STICK_W     = 8;

endpackage

// File: rtl/n64_poll_scheduler_if.sv
// Command/response handshake between the poll scheduler (master) and the
// N64 serial interface (slave).
interface n64_poll_scheduler_if;
  logic        poll_start;
  logic        ctrl_reset;
  logic        poll_done;
  logic        poll_error;
  logic [31:0] button_data;

  modport master (
    output poll_start, ctrl_reset,
    input  poll_done, poll_error, button_data
  );

  modport slave (
    input  poll_start, ctrl_reset,
    output poll_done, poll_error, button_data
  );
endinterface

// File: rtl/n64_down_counter.sv
// Loadable down-counter that stops at zero; zero flag reflects the current count.
module n64_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/n64_poll_scheduler.sv
// Poll scheduler FSM. state | meaning: IDLE disabled | WAIT period countdown |
// POLL transaction under watchdog | RESET_CTRL ctrl_reset held for RESET_HOLD cycles
module n64_poll_scheduler #(
  parameter int TIMEOUT_CYCLES = n64_pkg::TIMEOUT_CYCLES,
  parameter int MAX_FAILS      = n64_pkg::MAX_FAILS,
  parameter int RESET_HOLD     = n64_pkg::RESET_HOLD,
  parameter int PERIOD_W       = 24
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  sched_enable,
  input  logic                  reset_req,
  input  logic [PERIOD_W-1:0]   poll_period,
  n64_poll_scheduler_if.master  sif,
  output logic [31:0]           buttons,
  output logic                  buttons_valid,
  output logic                  connected,
  output logic [15:0]           poll_count,
  output logic [7:0]            fail_count
);
  import n64_pkg::*;

  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  sched_state_t        state;
  logic [FAIL_W-1:0]   consec_fails;
  logic [FAIL_W-1:0]   consec_next;
  logic [PERIOD_W-1:0] period_load;
  logic                wd_zero;
  logic                period_zero;
  logic                hold_zero;
  logic                fail_now;

  // Each counter reloads whenever its state is inactive, so it holds the
  // start value on the entry edge; poll_period is thus frozen at WAIT entry.
  assign period_load = (poll_period == '0) ? '0 : poll_period - PERIOD_W'(1);

  n64_down_counter #(.W(WD_W)) u_watchdog (
    .clk(PCLK), .rst(PRESET),
    .load(state != ST_POLL), .load_value(WD_W'(TIMEOUT_CYCLES - 1)),
    .en(state == ST_POLL), .zero(wd_zero)
  );

  n64_down_counter #(.W(PERIOD_W)) u_period (
    .clk(PCLK), .rst(PRESET),
    .load(state != ST_WAIT), .load_value(period_load),
    .en(state == ST_WAIT), .zero(period_zero)
  );

  n64_down_counter #(.W(HOLD_W)) u_hold (
    .clk(PCLK), .rst(PRESET),
    .load(state != ST_RESET_CTRL), .load_value(HOLD_W'(RESET_HOLD - 1)),
    .en(state == ST_RESET_CTRL), .zero(hold_zero)
  );

  // A done coinciding with an error is an error; done in the last watchdog cycle still counts
  assign fail_now    = sif.poll_error || (wd_zero && !sif.poll_done);
  assign consec_next = consec_fails + FAIL_W'(1);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state          <= ST_IDLE;
      consec_fails   <= '0;
      sif.poll_start <= 1'b0;
      sif.ctrl_reset <= 1'b0;
      buttons        <= '0;
      buttons_valid  <= 1'b0;
      connected      <= 1'b0;
      poll_count     <= '0;
      fail_count     <= '0;
    end else begin
      sif.poll_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (reset_req) begin
            state          <= ST_RESET_CTRL;
            sif.ctrl_reset <= 1'b1;
            buttons_valid  <= 1'b0;
          end else if (sched_enable) begin
            state          <= ST_POLL;
            sif.poll_start <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (reset_req) begin
            state          <= ST_RESET_CTRL;
            sif.ctrl_reset <= 1'b1;
            buttons_valid  <= 1'b0;
          end else if (!sched_enable) begin
            state <= ST_IDLE;
          end else if (period_zero) begin
            state          <= ST_POLL;
            sif.poll_start <= 1'b1;
          end
        end

        ST_POLL: begin
          if (reset_req) begin
            state          <= ST_RESET_CTRL;
            sif.ctrl_reset <= 1'b1;
            buttons_valid  <= 1'b0;
          end else if (fail_now) begin
            fail_count   <= (fail_count == 8'hFF) ? 8'hFF : fail_count + 8'd1;
            consec_fails <= consec_next;
            if (consec_next == FAIL_W'(MAX_FAILS)) begin
              state          <= ST_RESET_CTRL;
              sif.ctrl_reset <= 1'b1;
              connected      <= 1'b0;
              buttons_valid  <= 1'b0;
            end else begin
              state <= sched_enable ? ST_WAIT : ST_IDLE;
            end
          end else if (sif.poll_done) begin
            buttons       <= sif.button_data;
            buttons_valid <= 1'b1;
            connected     <= 1'b1;
            poll_count    <= poll_count + 16'd1;
            consec_fails  <= '0;
            state         <= sched_enable ? ST_WAIT : ST_IDLE;
          end
        end

        ST_RESET_CTRL: begin
          if (hold_zero) begin
            sif.ctrl_reset <= 1'b0;
            consec_fails   <= '0;
            state          <= sched_enable ? ST_WAIT : ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Directed bench for n64_poll_scheduler with a 200-cycle watchdog.
module tb_n64_poll_scheduler;
  logic        PCLK;
  logic        PRESET;
  logic        sched_enable;
  logic        reset_req;
  logic [23:0] poll_period;
  logic [31:0] buttons;
  logic        buttons_valid;
  logic        connected;
  logic [15:0] poll_count;
  logic [7:0]  fail_count;

  int compared;
  int mismatched;

  n64_poll_scheduler_if sif();

  n64_poll_scheduler #(
    .TIMEOUT_CYCLES(200), .MAX_FAILS(3), .RESET_HOLD(16), .PERIOD_W(24)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .sched_enable(sched_enable),
    .reset_req(reset_req), .poll_period(poll_period), .sif(sif),
    .buttons(buttons), .buttons_valid(buttons_valid), .connected(connected),
    .poll_count(poll_count), .fail_count(fail_count)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!sif.poll_start && n < 1000) begin
      tick();
      n++;
    end
    check(tag, {31'd0, sif.poll_start}, 32'd1);
  endtask

  task automatic wait_fail_change(input logic [7:0] old, output int k);
    k = 0;
    while (fail_count == old && k < 1000) begin
      tick();
      k++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_poll_start"}, {31'd0, sif.poll_start}, 32'd0);
    check({tag, "_ctrl_reset"}, {31'd0, sif.ctrl_reset}, 32'd0);
    check({tag, "_buttons"}, buttons, 32'd0);
    check({tag, "_buttons_valid"}, {31'd0, buttons_valid}, 32'd0);
    check({tag, "_connected"}, {31'd0, connected}, 32'd0);
    check({tag, "_poll_count"}, {16'd0, poll_count}, 32'd0);
    check({tag, "_fail_count"}, {24'd0, fail_count}, 32'd0);
  endtask

  initial begin
    int n;
    int k;
    compared        = 0;
    mismatched      = 0;
    PRESET          = 1'b1;
    sched_enable    = 1'b0;
    reset_req       = 1'b0;
    poll_period     = 24'd100;
    sif.poll_done   = 1'b0;
    sif.poll_error  = 1'b0;
    sif.button_data = 32'd0;
    repeat (3) tick();
    check_all_zero("reset");

    // Periodic poll: done 50 cycles into the transaction
    PRESET       = 1'b0;
    sched_enable = 1'b1;
    tick();
    check("first_start", {31'd0, sif.poll_start}, 32'd1);
    repeat (49) tick();
    sif.poll_done   = 1'b1;
    sif.button_data = 32'h8000_1234;
    tick();
    sif.poll_done = 1'b0;
    check("p1_buttons", buttons, 32'h8000_1234);
    check("p1_poll_count", {16'd0, poll_count}, 32'd1);
    check("p1_valid", {31'd0, buttons_valid}, 32'd1);
    check("p1_connected", {31'd0, connected}, 32'd1);
    n = 1;
    while (!sif.poll_start && n < 300) begin
      tick();
      n++;
    end
    check("p1_next_start_gap", n, 32'd101);

    // Error recovery: error, error, done
    sif.poll_error = 1'b1;
    tick();
    sif.poll_error = 1'b0;
    check("er1_fail_count", {24'd0, fail_count}, 32'd1);
    check("er1_connected", {31'd0, connected}, 32'd1);
    wait_start("er2_start");
    sif.poll_error = 1'b1;
    tick();
    sif.poll_error = 1'b0;
    check("er2_fail_count", {24'd0, fail_count}, 32'd2);
    wait_start("er3_start");
    sif.poll_done   = 1'b1;
    sif.button_data = 32'h0000_00FF;
    tick();
    sif.poll_done = 1'b0;
    check("er3_buttons", buttons, 32'h0000_00FF);
    check("er3_poll_count", {16'd0, poll_count}, 32'd2);
    check("er3_fail_count", {24'd0, fail_count}, 32'd2);
    check("er3_ctrl_reset", {31'd0, sif.ctrl_reset}, 32'd0);

    // Done and error together: error wins; consec count was cleared so no escalation
    wait_start("both_start");
    sif.poll_done   = 1'b1;
    sif.poll_error  = 1'b1;
    sif.button_data = 32'hDEAD_BEEF;
    tick();
    sif.poll_done  = 1'b0;
    sif.poll_error = 1'b0;
    check("both_buttons", buttons, 32'h0000_00FF);
    check("both_fail_count", {24'd0, fail_count}, 32'd3);
    check("both_poll_count", {16'd0, poll_count}, 32'd2);
    check("both_connected", {31'd0, connected}, 32'd1);
    check("both_ctrl_reset", {31'd0, sif.ctrl_reset}, 32'd0);

    // reset_req coinciding with poll_done
    wait_start("rr_start");
    sif.poll_done   = 1'b1;
    reset_req       = 1'b1;
    sif.button_data = 32'h1234_5678;
    tick();
    sif.poll_done = 1'b0;
    reset_req     = 1'b0;
    check("rr_ctrl_reset", {31'd0, sif.ctrl_reset}, 32'd1);
    check("rr_valid", {31'd0, buttons_valid}, 32'd0);
    check("rr_poll_count", {16'd0, poll_count}, 32'd2);
    check("rr_fail_count", {24'd0, fail_count}, 32'd3);
    check("rr_buttons", buttons, 32'h0000_00FF);
    n = 0;
    while (sif.ctrl_reset && n < 100) begin
      n++;
      tick();
    end
    check("rr_hold_cycles", n, 32'd16);

    // Timeout escalation: three unanswered polls
    wait_start("to1_start");
    wait_fail_change(8'd3, k);
    check("to1_latency", k, 32'd200);
    check("to1_fail_count", {24'd0, fail_count}, 32'd4);
    wait_start("to2_start");
    wait_fail_change(8'd4, k);
    check("to2_fail_count", {24'd0, fail_count}, 32'd5);
    check("to2_ctrl_reset", {31'd0, sif.ctrl_reset}, 32'd0);
    wait_start("to3_start");
    wait_fail_change(8'd5, k);
    check("to3_fail_count", {24'd0, fail_count}, 32'd6);
    check("to3_ctrl_reset", {31'd0, sif.ctrl_reset}, 32'd1);
    check("to3_connected", {31'd0, connected}, 32'd0);
    check("to3_valid", {31'd0, buttons_valid}, 32'd0);
    n = 0;
    while (sif.ctrl_reset && n < 100) begin
      n++;
      tick();
    end
    check("to3_hold_cycles", n, 32'd16);
    wait_start("resume_start");

    // PRESET in the middle of RESET_CTRL
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    check("pr_ctrl_reset_before", {31'd0, sif.ctrl_reset}, 32'd1);
    repeat (3) tick();
    PRESET = 1'b1;
    tick();
    check_all_zero("preset");
    PRESET = 1'b0;
    tick();
    check("pr_first_start", {31'd0, sif.poll_start}, 32'd1);

    // poll_period of 0 behaves as 1
    poll_period     = 24'd0;
    sif.poll_done   = 1'b1;
    sif.button_data = 32'hA5A5_0F0F;
    tick();
    sif.poll_done = 1'b0;
    check("z_poll_count", {16'd0, poll_count}, 32'd1);
    n = 1;
    while (!sif.poll_start && n < 50) begin
      tick();
      n++;
    end
    check("z_start_gap", n, 32'd2);

    // sched_enable dropped during POLL: failure still counted, then IDLE
    sched_enable   = 1'b0;
    sif.poll_error = 1'b1;
    tick();
    sif.poll_error = 1'b0;
    check("dis_fail_count", {24'd0, fail_count}, 32'd1);
    n = 0;
    repeat (30) begin
      if (sif.poll_start) n++;
      tick();
    end
    check("dis_no_start", n, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
